// File: rtl/dp_bram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Byte merge is written once here and used by both ports.
package dp_bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; narrower words are zero-extended.
  localparam int BE_MAX_W = 1024;
  localparam int BE_MAX_B = BE_MAX_W / 8;

  function automatic logic [BE_MAX_W-1:0] be_merge(
    input logic [BE_MAX_W-1:0] old_w,
    input logic [BE_MAX_W-1:0] new_w,
    input logic [BE_MAX_B-1:0] mask
  );
    logic [BE_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_MAX_B; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_bram_be_clr_if.sv
// One RAM access port: enable, byte mask, address, data, read return.
// The master drives the request, the RAM (slave) returns read data.
interface dp_bram_be_clr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                en;
  logic [DATA_W/8-1:0] we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (
    output en, we, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  en, we, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/dp_bram_rd_pipe.sv
// Read return pipeline: one stage, plus an optional output register.
// Data stages only load on valid so rdata holds between accesses.
module dp_bram_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  logic              v1;
  logic [DATA_W-1:0] d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) d1 <= in_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      logic              v2;
      logic [DATA_W-1:0] d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign rvalid = v2;
      assign rdata  = d2;
    end else begin : g_bypass
      assign rvalid = v1;
      assign rdata  = d1;
    end
  endgenerate

endmodule

// File: rtl/dp_bram_be_clr.sv
// True dual-port byte-enable RAM with collision flag and clear engine.
// The clear sweep borrows port A's write path while ports are blocked.
module dp_bram_be_clr
  import dp_bram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_req,
  output logic ready,
  output logic collision,
  dp_bram_be_clr_if.slave a,
  dp_bram_be_clr_if.slave b
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NB-1:0]     mask_t;

  function automatic word_t merge(word_t o, word_t n, mask_t m);
    return word_t'(be_merge(BE_MAX_W'(o), BE_MAX_W'(n), BE_MAX_B'(m)));
  endfunction

  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic ready_q;

  word_t mem [DEPTH];

  logic        clearing;
  logic        acc_a, acc_b;
  logic        wr_a, wr_b, same;
  logic [ADDR_W-1:0] wa_addr;
  mask_t       wa_mask;
  word_t       wa_data;
  word_t       old_a, old_b;
  word_t       word_a, word_b;
  word_t       rd_a, rd_b;

  assign ready = ready_q;

  always_comb begin
    state_n = state;
    unique case (state)
      ST_CLEAR: if (&ptr) state_n = ST_READY;
      ST_READY: if (clear_req) state_n = ST_CLEAR;
      default:  state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      ptr     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == ST_READY);
      if (state == ST_CLEAR) ptr <= ptr + 1'b1;
      else if (clear_req)    ptr <= '0;
    end
  end

  always_comb begin
    clearing = (state == ST_CLEAR);
    acc_a    = ready_q & a.en;
    acc_b    = ready_q & b.en;
    old_a    = mem[a.addr];
    old_b    = mem[b.addr];
    wa_addr  = clearing ? ptr : a.addr;
    wa_mask  = clearing ? '1 : a.we;
    wa_data  = clearing ? '0 : a.wdata;
    wr_a     = clearing | (acc_a & (|a.we));
    wr_b     = acc_b & (|b.we);
    word_a   = merge(mem[wa_addr], wa_data, wa_mask);
    same     = wr_a & wr_b & (wa_addr == b.addr);
    // On a shared address A owns its bytes; B fills only the rest.
    word_b   = merge(same ? word_a : old_b, b.wdata,
                     b.we & ~(same ? wa_mask : '0));
    rd_a     = (RDW_MODE == RDW_WRITE_FIRST) ?
               merge(old_a, a.wdata, a.we) : old_a;
    rd_b     = (RDW_MODE == RDW_WRITE_FIRST) ?
               merge(old_b, b.wdata, b.we) : old_b;
  end

  always_ff @(posedge clk) begin
    if (same) begin
      mem[b.addr] <= word_b;
    end else begin
      if (wr_a) mem[wa_addr] <= word_a;
      if (wr_b) mem[b.addr]  <= word_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else collision <= acc_a & acc_b & (a.addr == b.addr) & (|(a.we & b.we));
  end

  dp_bram_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc_a),
    .in_data  (rd_a),
    .rvalid   (a.rvalid),
    .rdata    (a.rdata)
  );

  dp_bram_rd_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc_b),
    .in_data  (rd_b),
    .rvalid   (b.rvalid),
    .rdata    (b.rdata)
  );

endmodule
